// File: rtl/sram_responder.sv
// sram_responder: sys_clk-oversampled model of a 16-bit asynchronous SRAM pin
// interface. Pins are synchronised through a common 2-stage pipeline, writes
// commit when the WE pulse ends, reads drive DQ per byte lane after READ_LAT.
// Optional power-up clear sweep is enabled by defining SRAM_RSP_INIT_EN.
module sram_responder #(
  parameter int          ADDR_W   = 8,
  parameter int          READ_LAT = 2,
  parameter logic [15:0] INIT_VAL = 16'h0000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [17:0] SRAM_ADDR,
  input  logic        SRAM_CE,
  input  logic        SRAM_OE,
  input  logic        SRAM_WE,
  input  logic        SRAM_UB,
  input  logic        SRAM_LB,
  inout  wire  [15:0] SRAM_DQ,
  output logic        busy,
  output logic [15:0] wr_cnt,
  output logic [15:0] rd_cnt
);

  typedef enum logic [2:0] {IDLE, WRITE, READ_WAIT, READ_DRIVE, CLEAR} state_t;

  localparam int     LAT_LAST = (READ_LAT > 0) ? READ_LAT - 1 : 0;
  localparam state_t RD_ENTRY = (READ_LAT == 0) ? READ_DRIVE : READ_WAIT;

  logic [15:0] mem [2**ADDR_W];

  logic [ADDR_W-1:0] addr_p1, addr_p2;
  logic [15:0]       dq_p1, dq_p2;
  logic              ce_p1, oe_p1, we_p1, ub_p1, lb_p1;
  logic              ce_p2, oe_p2, we_p2, ub_p2, lb_p2;

  state_t            state, state_nx;
  logic [3:0]        lat_cnt;
  logic [ADDR_W-1:0] hold_addr;
  logic [15:0]       hold_dq;
  logic              hold_ub, hold_lb;
  logic [15:0]       dq_q;

  logic              wr_act, rd_act, commit, rd_start;
  logic              mem_we_hi, mem_we_lo, drv_hi, drv_lo;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_din;

  logic unused_addr_hi;
  assign unused_addr_hi = ^SRAM_ADDR[17:ADDR_W];

`ifdef SRAM_RSP_INIT_EN
  logic [ADDR_W-1:0] clr_addr;

  // Clear-sweep address: restarts at 0 on every reset, advances once per CLEAR cycle
  always_ff @(posedge sys_clk) begin
    if (sys_rst) clr_addr <= '0;
    else if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
  end

  assign busy = (state == CLEAR);
`else
  logic unused_init;
  assign unused_init = ^INIT_VAL;
  assign busy = 1'b0;
`endif

  // Pin synchroniser: one common 2-stage pipeline keeps all pins mutually aligned
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      {ce_p1, oe_p1, we_p1, ub_p1, lb_p1} <= '1;
      {ce_p2, oe_p2, we_p2, ub_p2, lb_p2} <= '1;
      addr_p1 <= '0;
      addr_p2 <= '0;
      dq_p1   <= '0;
      dq_p2   <= '0;
    end else begin
      {ce_p1, oe_p1, we_p1, ub_p1, lb_p1} <= {SRAM_CE, SRAM_OE, SRAM_WE, SRAM_UB, SRAM_LB};
      addr_p1 <= SRAM_ADDR[ADDR_W-1:0];
      dq_p1   <= SRAM_DQ;
      // stage 2: decode point
      {ce_p2, oe_p2, we_p2, ub_p2, lb_p2} <= {ce_p1, oe_p1, we_p1, ub_p1, lb_p1};
      addr_p2 <= addr_p1;
      dq_p2   <= dq_p1;
    end
  end

  // WE low overrides OE, so both decodes can never be active together
  assign wr_act = !ce_p2 && !we_p2;
  assign rd_act = !ce_p2 && !oe_p2 && we_p2;

  // State register, read-latency counter and transaction counters
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
`ifdef SRAM_RSP_INIT_EN
      state <= CLEAR;
`else
      state <= IDLE;
`endif
      lat_cnt <= '0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
    end else begin
      state   <= state_nx;
      lat_cnt <= (state == READ_WAIT) ? lat_cnt + 1'b1 : 4'd0;
      if (commit)   wr_cnt <= wr_cnt + 1'b1;
      if (rd_start) rd_cnt <= rd_cnt + 1'b1;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (wr_act)      state_nx = WRITE;
        else if (rd_act) state_nx = RD_ENTRY;
      end
      WRITE: begin
        if (!wr_act) state_nx = rd_act ? RD_ENTRY : IDLE;
      end
      READ_WAIT: begin
        if (wr_act)                        state_nx = WRITE;
        else if (!rd_act)                  state_nx = IDLE;
        else if (lat_cnt == 4'(LAT_LAST))  state_nx = READ_DRIVE;
      end
      READ_DRIVE: begin
        if (wr_act)       state_nx = WRITE;
        else if (!rd_act) state_nx = IDLE;
      end
      CLEAR: begin
`ifdef SRAM_RSP_INIT_EN
        if (clr_addr == '1) state_nx = IDLE;
`else
        state_nx = IDLE;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output decode: commit strobes, array write port mux and DQ lane enables
  always_comb begin
    commit    = (state == WRITE) && !wr_act && !sys_rst;
    rd_start  = rd_act && ((state == IDLE) || (state == WRITE));
    mem_we_hi = commit && !hold_ub;
    mem_we_lo = commit && !hold_lb;
    mem_addr  = hold_addr;
    mem_din   = hold_dq;
`ifdef SRAM_RSP_INIT_EN
    if (state == CLEAR) begin
      mem_we_hi = 1'b1;
      mem_we_lo = 1'b1;
      mem_addr  = clr_addr;
      mem_din   = INIT_VAL;
    end
`endif
    drv_hi = (state == READ_DRIVE) && !ub_p2;
    drv_lo = (state == READ_DRIVE) && !lb_p2;
  end

  // Write holding registers: track the bus on every cycle the write is active
  always_ff @(posedge sys_clk) begin
    if (wr_act && (state != CLEAR)) begin
      hold_addr <= addr_p2;
      hold_dq   <= dq_p2;
      hold_ub   <= ub_p2;
      hold_lb   <= lb_p2;
    end
  end

  // Block-RAM array: byte-lane writes and a registered read re-sampled every cycle
  always_ff @(posedge sys_clk) begin
    if (mem_we_hi) mem[mem_addr][15:8] <= mem_din[15:8];
    if (mem_we_lo) mem[mem_addr][7:0]  <= mem_din[7:0];
    dq_q <= mem[addr_p2];
  end

  assign SRAM_DQ[15:8] = drv_hi ? dq_q[15:8] : 8'bz;
  assign SRAM_DQ[7:0]  = drv_lo ? dq_q[7:0]  : 8'bz;

endmodule
